// File: rtl/packed_trace_buffer_pkg.sv
// Shared types and constants for the packed trace buffer.
package lebug_pkg;

    typedef enum logic [1:0] {
        TB_IDLE  = 2'd0,
        TB_TRACE = 2'd1,
        TB_DRAIN = 2'd2
    } tb_state_t;

    localparam logic TB_MODE_CIRCULAR = 1'b0;
    localparam logic TB_MODE_STOP     = 1'b1;

endpackage

// File: rtl/packed_trace_buffer_if.sv
// Capture-side and drain-side stream signals of the trace buffer.
interface packed_trace_buffer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
);
    logic                           valid_in;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
    logic                           out_ready;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
    logic                           out_valid;
    logic                           out_last;

    // Packer / downstream consumer side.
    modport master (
        output valid_in,
        output vector_in,
        output out_ready,
        input  vector_out,
        input  out_valid,
        input  out_last
    );

    // Trace buffer side.
    modport slave (
        input  valid_in,
        input  vector_in,
        input  out_ready,
        output vector_out,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/packed_trace_buffer_ram.sv
// Trace storage: one write port, one registered read port. The read
// register doubles as the drained output vector, so it holds when rd_en=0.
module tb_ram #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Array write; contents are not reset, count/pointers define validity.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    // Synchronous read register, cleared on reset so vector_out starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/packed_trace_buffer.sv
// Circular capture buffer for packed vectors with oldest-first drain.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   TB_IDLE  | config/readout phase, contents held, waiting for trace or rd_start
//   TB_TRACE | capturing valid_in vectors into the ring
//   TB_DRAIN | streaming stored vectors out over valid/ready
module packed_trace_buffer
    import lebug_pkg::*;
#(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int TB_SIZE            = 16,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int INITIAL_MODE       = 0,
    localparam int PW                = $clog2(TB_SIZE),
    localparam int CW                = $clog2(TB_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tracing,
    input  logic [7:0]             configId,
    input  logic [7:0]             configData,
    input  logic                   rd_start,
    packed_trace_buffer_if.slave   bus,
    output logic                   full,
    output logic [CW-1:0]          entries
);
    tb_state_t      state_q, state_d;
    logic [PW-1:0]  wr_ptr, rd_ptr, rd_addr, oldest;
    logic [CW-1:0]  count, remain;
    logic           mode;
    logic           out_valid_q, out_last_q;
    logic           enter_trace, start_drain, pop, rd_en, capture, we;
    logic [N*DATA_WIDTH-1:0] rd_data;

    assign full    = (count == CW'(TB_SIZE));
    assign entries = count;

    // When full the truncated count is zero, so oldest collapses to wr_ptr.
    assign oldest  = wr_ptr - count[PW-1:0];

    assign capture = (state_q == TB_TRACE) && tracing && bus.valid_in;
    assign we      = capture && (!full || mode == TB_MODE_CIRCULAR);

    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.vector_out = rd_data;

    tb_ram #(
        .WIDTH (N*DATA_WIDTH),
        .DEPTH (TB_SIZE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (bus.vector_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= TB_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode plus the read-port and pointer strobes.
    always_comb begin
        state_d     = state_q;
        enter_trace = 1'b0;
        start_drain = 1'b0;
        pop         = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = rd_ptr;
        case (state_q)
            TB_IDLE: begin
                if (tracing) begin
                    state_d     = TB_TRACE;
                    enter_trace = 1'b1;
                end else if (rd_start && count != '0) begin
                    state_d     = TB_DRAIN;
                    start_drain = 1'b1;
                    rd_en       = 1'b1;
                    rd_addr     = oldest;
                end
            end
            TB_TRACE: begin
                if (!tracing) state_d = TB_IDLE;
            end
            TB_DRAIN: begin
                if (tracing) begin
                    state_d     = TB_TRACE;
                    enter_trace = 1'b1;
                end else if (out_valid_q && bus.out_ready) begin
                    pop = 1'b1;
                    if (remain > CW'(1)) begin
                        rd_en   = 1'b1;
                        rd_addr = rd_ptr + PW'(1);
                    end else begin
                        state_d = TB_IDLE;
                    end
                end
            end
            default: state_d = TB_IDLE;
        endcase
    end

    // Pointers, stored count, drain down-counter and output qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            remain      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (enter_trace) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            remain      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (capture) begin
                if (!full) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    count  <= count + CW'(1);
                end else if (mode == TB_MODE_CIRCULAR) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rd_ptr <= wr_ptr + PW'(1);
                end
            end
            if (start_drain) begin
                rd_ptr      <= oldest;
                remain      <= count;
                out_valid_q <= 1'b1;
                out_last_q  <= (count == CW'(1));
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                remain <= remain - CW'(1);
                if (remain > CW'(1)) begin
                    out_last_q <= (remain == CW'(2));
                end else begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            end
        end
    end

    // Capture mode; only bit 0 of the config byte is defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode <= 1'(INITIAL_MODE);
        else if (!tracing && configId == 8'(PERSONAL_CONFIG_ID))
            mode <= configData[0];
    end
endmodule

// File: tb/tb_packed_trace_buffer.sv
// Directed self-checking bench for packed_trace_buffer.
module tb_packed_trace_buffer;
    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int TBS = 16;
    localparam int CW  = $clog2(TBS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tracing = 1'b0;
    logic          rd_start = 1'b0;
    logic [7:0]    configId = 8'hFF;
    logic [7:0]    configData = 8'h00;
    logic          full;
    logic [CW-1:0] entries;

    int checks = 0;
    int errors = 0;

    packed_trace_buffer_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    packed_trace_buffer #(
        .N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS),
        .PERSONAL_CONFIG_ID(0), .INITIAL_MODE(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tracing    (tracing),
        .configId   (configId),
        .configData (configData),
        .rd_start   (rd_start),
        .bus        (bus.slave),
        .full       (full),
        .entries    (entries)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0][DW-1:0] mkvec(input int v);
        logic [N-1:0][DW-1:0] r;
        for (int k = 0; k < N; k++) r[k] = {8'(k), 24'(v)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        bus.valid_in  = 1'b1;
        bus.vector_in = mkvec(v);
        tick();
        bus.valid_in  = 1'b0;
    endtask

    task automatic trace(input int first, input int last);
        tracing = 1'b1;
        tick();
        for (int v = first; v <= last; v++) push(v);
        tracing = 1'b0;
        tick();
    endtask

    task automatic drain(input string tag, input int first, input int cnt);
        logic [N-1:0][DW-1:0] e;
        bus.out_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            e = mkvec(first + i);
            chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
            chk({tag, "_lane0"}, 64'(bus.vector_out[0]), 64'(e[0]));
            chk({tag, "_lane7"}, 64'(bus.vector_out[N-1]), 64'(e[N-1]));
            chk({tag, "_last"}, 64'(bus.out_last), 64'(i == cnt - 1));
            tick();
        end
        chk({tag, "_end_valid"}, 64'(bus.out_valid), 64'(0));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0] pat;
        logic       rdy;
        int         exp_v;
        pat = 4'b1001;
        bus.valid_in  = 1'b0;
        bus.vector_in = '0;
        bus.out_ready = 1'b0;

        // reset state
        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_last", 64'(bus.out_last), 64'(0));
        chk("rst_entries", 64'(entries), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_vec", 64'(bus.vector_out[0]), 64'(0));
        #5 rst_n = 1'b1;
        tick();

        // rd_start on empty buffer is ignored
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("empty_rd_v0", 64'(bus.out_valid), 64'(0));
        tick();
        chk("empty_rd_v1", 64'(bus.out_valid), 64'(0));

        // 5 vectors, straight drain, then non-destructive re-read
        trace(1, 5);
        chk("t2_entries", 64'(entries), 64'(5));
        chk("t2_full", 64'(full), 64'(0));
        drain("t2", 1, 5);
        chk("t2_entries_kept", 64'(entries), 64'(5));
        drain("t2_reread", 1, 5);

        // circular overwrite: oldest four lost
        trace(1, 20);
        chk("t3_full", 64'(full), 64'(1));
        chk("t3_entries", 64'(entries), 64'(16));
        drain("t3", 5, 16);

        // stop-when-full mode: 17..20 dropped
        configId = 8'h00;
        configData = 8'h01;
        tick();
        configId = 8'hFF;
        configData = 8'h00;
        trace(1, 20);
        chk("t4_full", 64'(full), 64'(1));
        chk("t4_entries", 64'(entries), 64'(16));
        drain("t4", 1, 16);

        // drain with out_ready pattern 1,0,0,1
        trace(1, 5);
        exp_v = 1;
        bus.out_ready = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int c = 0; c < 40 && exp_v <= 5; c++) begin
            chk("t5_valid", 64'(bus.out_valid), 64'(1));
            chk("t5_lane0", 64'(bus.vector_out[0]), 64'({8'd0, 24'(exp_v)}));
            chk("t5_lane7", 64'(bus.vector_out[N-1]), 64'({8'd7, 24'(exp_v)}));
            chk("t5_last", 64'(bus.out_last), 64'(exp_v == 5));
            bus.out_ready = pat[c % 4];
            rdy = bus.out_ready;
            tick();
            if (rdy) exp_v++;
        end
        bus.out_ready = 1'b0;
        chk("t5_count", 64'(exp_v), 64'(6));
        chk("t5_end_valid", 64'(bus.out_valid), 64'(0));

        // tracing rises mid-drain after two outputs
        trace(1, 5);
        bus.out_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("t6_first", 64'(bus.vector_out[0]), 64'(1));
        tick();
        chk("t6_second", 64'(bus.vector_out[0]), 64'(2));
        tick();
        chk("t6_third", 64'(bus.vector_out[0]), 64'(3));
        tracing = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        chk("t6_abort_valid", 64'(bus.out_valid), 64'(0));
        chk("t6_abort_entries", 64'(entries), 64'(0));
        push(42);
        chk("t6_new_entries", 64'(entries), 64'(1));
        tracing = 1'b0;
        tick();
        drain("t6_new", 42, 1);

        // asynchronous reset mid-drain
        trace(1, 3);
        bus.out_ready = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("t1_pre_valid", 64'(bus.out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("t1_rst_entries", 64'(entries), 64'(0));
        chk("t1_rst_last", 64'(bus.out_last), 64'(0));
        #3 rst_n = 1'b1;
        tick();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("t1_post_v0", 64'(bus.out_valid), 64'(0));
        tick();
        chk("t1_post_v1", 64'(bus.out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
